// File: rtl/bit_count_unit.sv
// Population counter: counts ones (mode=0) or zeros (mode=1) in data_in by shifting the operand out MSB-first.
// Latency N+1 cycles after accept (N = DATA_W - lowest set bit index of operand); ready/done are Moore-decoded, abort cancels.
module bit_count_unit #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              abort,
    output logic              ready,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   r1_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ready_q;
    logic                done_q;

    // ready/done are registered alongside the state so they are pure Moore outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            r1_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            r1_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        r1_q    <= data_in ^ {DATA_W{mode}};
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                        ready_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    // Once the remaining operand is empty no further ones can appear.
                    if (r1_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        r1_q  <= r1_q << 1;
                        cnt_q <= cnt_q + CNT_W'(r1_q[DATA_W-1]);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    r1_q    <= '0;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign count = cnt_q;

endmodule

// File: tb/tb_bit_count_unit.sv
// Directed bench for bit_count_unit (DATA_W=8): latency, count value, ignored inputs, abort/reset and back-to-back starts.
module tb_bit_count_unit;

    logic       clk;
    logic       rst_b;
    logic       start;
    logic       mode;
    logic [7:0] data_in;
    logic       abort;
    logic       ready;
    logic       done;
    logic [3:0] count;

    int n_checks;
    int n_fail;

    bit_count_unit #(.DATA_W(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .start   (start),
        .mode    (mode),
        .data_in (data_in),
        .abort   (abort),
        .ready   (ready),
        .done    (done),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts from IDLE; checks done arrives exactly exp_n+1 edges after accept with exp_cnt.
    task automatic run_op(input string tag, input logic [7:0] d, input logic m,
                          input int exp_n, input int exp_cnt);
        int cycles;
        check({tag, " ready before"}, 32'(ready), 32'd1);
        start   = 1'b1;
        data_in = d;
        mode    = m;
        step();
        start   = 1'b0;
        check({tag, " ready after accept"}, 32'(ready), 32'd0);
        cycles = 0;
        while (!done && cycles < 20) begin
            step();
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'(exp_n + 1));
        check({tag, " count"}, 32'(count), 32'(exp_cnt));
        step();
        check({tag, " done single"}, 32'(done), 32'd0);
        check({tag, " ready back"}, 32'(ready), 32'd1);
        step();
        check({tag, " count held"}, 32'(count), 32'(exp_cnt));
    endtask

    initial begin
        int first_done;
        int pulses;
        int last;
        n_checks = 0;
        n_fail   = 0;
        rst_b    = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        data_in  = 8'h00;
        abort    = 1'b0;

        // Reset acts with no clock edge.
        #1 rst_b = 1'b0;
        #2;
        check("rst ready", 32'(ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst count", 32'(count), 32'd0);
        step();
        rst_b = 1'b1;

        run_op("ones b4", 8'b1011_0100, 1'b0, 6, 4);
        run_op("zero op", 8'h00, 1'b0, 0, 0);
        run_op("ff zeros", 8'hFF, 1'b1, 0, 0);
        run_op("zeros full", 8'h00, 1'b1, 8, 8);
        run_op("zeros 01", 8'h01, 1'b1, 7, 7);
        run_op("ones ff", 8'hFF, 1'b0, 8, 8);

        // Start/data/mode changes during SHIFT must not disturb the operation.
        start = 1'b1; data_in = 8'h01; mode = 1'b0;
        step();
        start = 1'b0;
        first_done = -1;
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 2) begin
                start = 1'b1; data_in = 8'hFF; mode = 1'b1;
            end
            step();
            if (i == 2) start = 1'b0;
            if (done) begin
                pulses++;
                if (first_done < 0) begin
                    first_done = i;
                    check("ignore count", 32'(count), 32'd1);
                end
            end
        end
        check("ignore latency", 32'(first_done), 32'd9);
        check("ignore pulses", 32'(pulses), 32'd1);

        // Abort in the 3rd SHIFT cycle of 8'hF0.
        start = 1'b1; data_in = 8'hF0; mode = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        check("abort partial count", 32'(count), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort ready", 32'(ready), 32'd1);
        check("abort count", 32'(count), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            step();
        end
        check("abort no done", 32'(pulses), 32'd0);
        run_op("after abort", 8'h81, 1'b0, 8, 2);

        // Reset in the 3rd SHIFT cycle of 8'hF0.
        start = 1'b1; data_in = 8'hF0; mode = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst_b = 1'b0;
        #1;
        check("midrst ready", 32'(ready), 32'd1);
        check("midrst count", 32'(count), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        step();
        rst_b = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            step();
        end
        check("midrst no done", 32'(pulses), 32'd0);
        run_op("after rst", 8'h81, 1'b0, 8, 2);

        // Abort wins over start in IDLE.
        start = 1'b1; abort = 1'b1; data_in = 8'hFF; mode = 1'b0;
        step();
        start = 1'b0; abort = 1'b0;
        check("abort over start ready", 32'(ready), 32'd1);
        check("abort over start count", 32'(count), 32'd0);

        // Back-to-back with start held: done every 4th cycle.
        start = 1'b1; data_in = 8'h80; mode = 1'b0;
        pulses = 0;
        last = -1;
        for (int i = 0; i < 17; i++) begin
            step();
            if (done) begin
                pulses++;
                check("b2b count", 32'(count), 32'd1);
                if (last < 0) check("b2b first", 32'(i), 32'd2);
                else check("b2b period", 32'(i - last), 32'd4);
                last = i;
            end
        end
        check("b2b pulses", 32'(pulses), 32'd4);
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("final ready", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
